// File: rtl/safe_lock_fsm.sv
// Keypad safe-lock controller: four-digit entry, timed unlock/fail/lockout dwells
// and an emergency override. All outputs are registered.
module safe_lock_fsm #(
  parameter logic [15:0] PASSWORD         = 16'h1234,
  parameter int          UNLOCK_MS        = 3000,
  parameter int          FAIL_MS          = 1000,
  parameter int          LOCKOUT_MS       = 10000,
  parameter int          MAX_FAIL         = 3,
  parameter int          ENTRY_TIMEOUT_MS = 5000
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       emergency,
  output logic [3:0] state,
  output logic       lock_open,
  output logic [2:0] fail_cnt
);

  // state     | meaning
  // IDLE      | waiting for the first digit
  // IN1..IN3  | one to three digits entered
  // VERIFY    | single-cycle compare of the entry buffer
  // UNLOCK    | bolt released for UNLOCK_MS or until lock key
  // FAIL      | wrong code penalty for FAIL_MS
  // LOCKOUT   | keypad disabled for LOCKOUT_MS
  // EMERGENCY | held while emergency is asserted
  localparam logic [3:0] ST_IDLE    = 4'b0000;
  localparam logic [3:0] ST_IN1     = 4'b0001;
  localparam logic [3:0] ST_IN2     = 4'b0010;
  localparam logic [3:0] ST_IN3     = 4'b0011;
  localparam logic [3:0] ST_VERIFY  = 4'b0100;
  localparam logic [3:0] ST_UNLOCK  = 4'b0111;
  localparam logic [3:0] ST_FAIL    = 4'b1000;
  localparam logic [3:0] ST_LOCKOUT = 4'b1001;
  localparam logic [3:0] ST_EMERG   = 4'b1010;

  localparam logic [13:0] CNT_MAX      = 14'h3FFF;
  localparam logic [13:0] UNLOCK_LAST  = 14'(UNLOCK_MS - 1);
  localparam logic [13:0] FAIL_LAST    = 14'(FAIL_MS - 1);
  localparam logic [13:0] LOCKOUT_LAST = 14'(LOCKOUT_MS - 1);
  localparam logic [13:0] ENTRY_LAST   = 14'(ENTRY_TIMEOUT_MS - 1);

  logic [3:0]  state_n;
  logic [15:0] buf_q, buf_n;
  logic [13:0] cnt_q, cnt_n;
  logic [2:0]  fail_n;
  logic        lock_n;
  logic        changed;
  logic        in_entry, digit_key, clr_key, lock_key;

  assign in_entry  = state inside {ST_IDLE, ST_IN1, ST_IN2, ST_IN3};
  assign digit_key = key_valid && (key_code <= 4'd9);
  assign clr_key   = key_valid && (key_code == 4'hA);
  assign lock_key  = key_valid && (key_code == 4'hB);

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lock_open <= 1'b0;
      fail_cnt  <= 3'd0;
      buf_q     <= 16'h0000;
      cnt_q     <= 14'd0;
    end else begin
      state     <= state_n;
      lock_open <= lock_n;
      fail_cnt  <= fail_n;
      buf_q     <= buf_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    if (emergency) begin
      state_n = ST_EMERG;
    end else begin
      case (state)
        ST_IDLE, ST_IN1, ST_IN2, ST_IN3: begin
          if (digit_key)
            state_n = (state == ST_IN3) ? ST_VERIFY : state + 4'd1;
          else if (clr_key)
            state_n = ST_IDLE;
          else if (state != ST_IDLE && cnt_q == ENTRY_LAST)
            state_n = ST_IDLE;
        end
        ST_VERIFY:  state_n = (buf_q == PASSWORD) ? ST_UNLOCK : ST_FAIL;
        ST_UNLOCK:  if (lock_key || cnt_q == UNLOCK_LAST) state_n = ST_IDLE;
        ST_FAIL: begin
          if (cnt_q == FAIL_LAST)
            state_n = (int'(fail_cnt) >= MAX_FAIL) ? ST_LOCKOUT : ST_IDLE;
        end
        ST_LOCKOUT: if (cnt_q == LOCKOUT_LAST) state_n = ST_IDLE;
        ST_EMERG:   state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    changed = (state_n != state);
    cnt_n   = changed ? 14'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 14'd1);

    buf_n = buf_q;
    if (!emergency && in_entry && digit_key) buf_n = {buf_q[11:0], key_code};
    if (!emergency && in_entry && clr_key)   buf_n = 16'h0000;
    if (changed && (state_n inside {ST_IDLE, ST_UNLOCK, ST_FAIL, ST_LOCKOUT, ST_EMERG}))
      buf_n = 16'h0000;

    fail_n = fail_cnt;
    if (changed) begin
      if (state_n == ST_UNLOCK)
        fail_n = 3'd0;
      else if (state_n == ST_FAIL && fail_cnt != 3'd7)
        fail_n = fail_cnt + 3'd1;
      else if (state == ST_LOCKOUT && state_n == ST_IDLE)
        fail_n = 3'd0;
    end

    lock_n = (state_n == ST_UNLOCK);
  end

endmodule
